// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// program-load sequencing onto the instruction-memory write port.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | fetching; PC advances, redirects, or stalls
// LOAD  | PC/IM_WE/IM_W_Ins driven from the load word stream
// HALT  | halt word fetched or PC left IMEM range; waits for RST/Load_Start
module fetch_unit #(
    parameter int          IMEM_SIZE = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Load_Start,
    input  logic        Load_Valid,
    input  logic [31:0] Load_Data,
    input  logic        Load_Done,
    input  logic        Stall,
    input  logic        Br_Taken,
    input  logic [31:0] Br_Target,
    input  logic        Jmp,
    input  logic [31:0] Jmp_Target,
    input  logic [31:0] Ins,
    output logic [31:0] PC,
    output logic        IM_WE,
    output logic [31:0] IM_W_Ins,
    output logic [31:0] ID_Ins,
    output logic [31:0] ID_PC4,
    output logic        ID_Valid,
    output logic        Halted,
    output logic        Addr_Err,
    output logic        Load_Ovf
);

    // Load address must be able to hold IMEM_SIZE itself (the overflow slot).
    localparam int                LA_W     = $clog2(IMEM_SIZE) + 1;
    localparam logic [LA_W-1:0]   LA_MAX   = LA_W'(IMEM_SIZE);
    localparam logic [31:0]       PC_LIMIT = 32'(IMEM_SIZE * 4);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       id_ins_q, id_ins_d;
    logic [31:0]       id_pc4_q, id_pc4_d;
    logic              id_valid_q, id_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              load_ovf_q, load_ovf_d;
    logic [LA_W-1:0]   load_addr_q, load_addr_d;

    logic              load_room;
    logic [31:0]       pc_plus4;

    assign load_room = load_addr_q < LA_MAX;
    assign pc_plus4  = pc_q + 32'd4;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            id_ins_q    <= 32'h0;
            id_pc4_q    <= 32'h0;
            id_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            load_ovf_q  <= 1'b0;
            load_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_ins_q    <= id_ins_d;
            id_pc4_q    <= id_pc4_d;
            id_valid_q  <= id_valid_d;
            addr_err_q  <= addr_err_d;
            load_ovf_q  <= load_ovf_d;
            load_addr_q <= load_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_ins_d    = id_ins_q;
        id_pc4_d    = id_pc4_q;
        id_valid_d  = id_valid_q;
        addr_err_d  = addr_err_q;
        load_ovf_d  = load_ovf_q;
        load_addr_d = load_addr_q;

        case (state_q)
            ST_LOAD: begin
                if (Load_Valid) begin
                    if (load_room) load_addr_d = load_addr_q + 1'b1;
                    else           load_ovf_d  = 1'b1;
                end
                if (Load_Done) begin
                    state_d    = ST_RUN;
                    pc_d       = RESET_PC;
                    id_valid_d = 1'b0;
                end
            end
            ST_HALT: begin
                id_valid_d = 1'b0;
                if (Load_Start) begin
                    state_d     = ST_LOAD;
                    load_ovf_d  = 1'b0;
                    load_addr_d = '0;
                end
            end
            default: begin
                if (Load_Start) begin
                    state_d     = ST_LOAD;
                    id_valid_d  = 1'b0;
                    load_ovf_d  = 1'b0;
                    load_addr_d = '0;
                end else if (!Stall) begin
                    // Redirects squash the wrong-path word instead of latching it.
                    if (Br_Taken) begin
                        pc_d       = Br_Target & ~32'h3;
                        id_valid_d = 1'b0;
                    end else if (Jmp) begin
                        pc_d       = Jmp_Target & ~32'h3;
                        id_valid_d = 1'b0;
                    end else if (pc_q >= PC_LIMIT) begin
                        id_valid_d = 1'b0;
                        addr_err_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        id_ins_d   = Ins;
                        id_pc4_d   = pc_plus4;
                        id_valid_d = 1'b1;
                        if (Ins == HALT_WORD) state_d = ST_HALT;
                        else                  pc_d    = pc_plus4;
                    end
                end
            end
        endcase
    end

    assign PC       = (state_q == ST_LOAD) ? {{(30 - LA_W){1'b0}}, load_addr_q, 2'b00} : pc_q;
    assign IM_WE    = !RST && (state_q == ST_LOAD) && Load_Valid && load_room;
    assign IM_W_Ins = Load_Data;
    assign ID_Ins   = id_ins_q;
    assign ID_PC4   = id_pc4_q;
    assign ID_Valid = id_valid_q;
    assign Halted   = (state_q == ST_HALT);
    assign Addr_Err = addr_err_q;
    assign Load_Ovf = load_ovf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a behavioural model of fetch/load
// rules, with an instruction memory that the DUT itself loads.
module tb_fetch_unit;

    localparam int          IMEM_SIZE = 256;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam int          M_RUN = 0, M_LOAD = 1, M_HALT = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Load_Start, Load_Valid, Load_Done, Stall, Br_Taken, Jmp;
    logic [31:0] Load_Data, Br_Target, Jmp_Target, Ins;
    logic [31:0] PC, IM_W_Ins, ID_Ins, ID_PC4;
    logic        IM_WE, ID_Valid, Halted, Addr_Err, Load_Ovf;

    fetch_unit dut (
        .CLK(CLK), .RST(RST),
        .Load_Start(Load_Start), .Load_Valid(Load_Valid), .Load_Data(Load_Data),
        .Load_Done(Load_Done), .Stall(Stall), .Br_Taken(Br_Taken),
        .Br_Target(Br_Target), .Jmp(Jmp), .Jmp_Target(Jmp_Target), .Ins(Ins),
        .PC(PC), .IM_WE(IM_WE), .IM_W_Ins(IM_W_Ins), .ID_Ins(ID_Ins),
        .ID_PC4(ID_PC4), .ID_Valid(ID_Valid), .Halted(Halted),
        .Addr_Err(Addr_Err), .Load_Ovf(Load_Ovf)
    );

    always #5 CLK = ~CLK;

    // Memory seen by the DUT, written only through its IM write port.
    logic [31:0] imem [IMEM_SIZE];
    assign Ins = (PC < 32'(IMEM_SIZE * 4)) ? imem[PC[9:2]] : 32'h0;

    // Reference model state.
    logic [31:0] m_imem [IMEM_SIZE];
    int          m_state, m_la;
    logic [31:0] m_pc, m_id_ins, m_id_pc4;
    logic        m_id_v, m_aerr, m_lovf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_pc_out();
        return (m_state == M_LOAD) ? 32'(m_la * 4) : m_pc;
    endfunction

    function automatic logic m_we();
        return !RST && m_state == M_LOAD && Load_Valid && m_la < IMEM_SIZE;
    endfunction

    task automatic model_reset();
        m_state = M_RUN; m_pc = 0; m_la = 0;
        m_id_ins = 0; m_id_pc4 = 0; m_id_v = 0; m_aerr = 0; m_lovf = 0;
    endtask

    task automatic model_step();
        logic [31:0] word;
        if (RST) begin
            model_reset();
        end else if (m_state == M_LOAD) begin
            if (Load_Valid) begin
                if (m_la < IMEM_SIZE) begin
                    m_imem[m_la] = Load_Data;
                    m_la++;
                end else m_lovf = 1;
            end
            if (Load_Done) begin
                m_state = M_RUN; m_pc = 0; m_id_v = 0;
            end
        end else if (Load_Start) begin
            m_state = M_LOAD; m_id_v = 0; m_lovf = 0; m_la = 0;
        end else if (m_state == M_HALT) begin
            m_id_v = 0;
        end else if (!Stall) begin
            if (Br_Taken) begin
                m_pc = Br_Target - (Br_Target % 4); m_id_v = 0;
            end else if (Jmp) begin
                m_pc = Jmp_Target - (Jmp_Target % 4); m_id_v = 0;
            end else if (m_pc >= IMEM_SIZE * 4) begin
                m_id_v = 0; m_aerr = 1; m_state = M_HALT;
            end else begin
                word     = m_imem[m_pc / 4];
                m_id_ins = word;
                m_id_pc4 = m_pc + 4;
                m_id_v   = 1;
                if (word == HALT_WORD) m_state = M_HALT;
                else                   m_pc    = m_pc + 4;
            end
        end
    endtask

    task automatic idle();
        RST = 0; Load_Start = 0; Load_Valid = 0; Load_Data = 0; Load_Done = 0;
        Stall = 0; Br_Taken = 0; Br_Target = 0; Jmp = 0; Jmp_Target = 0;
    endtask

    // Entered just after a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        logic        w_en;
        logic [31:0] w_a, w_d;
        #1;
        chk("pc", PC, m_pc_out());
        chk("im_we", 32'(IM_WE), 32'(m_we()));
        if (m_we()) chk("im_w_ins", IM_W_Ins, Load_Data);
        chk("id_valid", 32'(ID_Valid), 32'(m_id_v));
        if (m_id_v) begin
            chk("id_ins", ID_Ins, m_id_ins);
            chk("id_pc4", ID_PC4, m_id_pc4);
        end
        chk("halted", 32'(Halted), 32'(m_state == M_HALT));
        chk("addr_err", 32'(Addr_Err), 32'(m_aerr));
        chk("load_ovf", 32'(Load_Ovf), 32'(m_lovf));
        w_en = IM_WE; w_a = PC; w_d = IM_W_Ins;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        if (w_en) imem[w_a[9:2]] = w_d;
    endtask

    function automatic logic [31:0] rand_word();
        return ($urandom_range(0, 15) == 0) ? HALT_WORD : $urandom();
    endfunction

    initial begin
        for (int i = 0; i < IMEM_SIZE; i++) begin
            imem[i] = 0; m_imem[i] = 0;
        end
        idle();
        RST = 1;
        repeat (2) @(posedge CLK);
        model_reset();
        @(negedge CLK);
        RST = 0;
        chk("rst_pc", PC, 32'h0);
        chk("rst_id_valid", 32'(ID_Valid), 32'h0);
        chk("rst_halted", 32'(Halted), 32'h0);

        // Program load: four words then a halt word at 0x10.
        Load_Start = 1; step(); idle();
        for (int i = 0; i < 5; i++) begin
            Load_Valid = 1;
            Load_Data  = (i == 4) ? HALT_WORD : 32'h2008_0001 + 32'(i);
            #1;
            chk("load_we", 32'(IM_WE), 32'h1);
            chk("load_pc", PC, 32'(i * 4));
            step();
        end
        idle(); Load_Done = 1; step(); idle();
        chk("post_load_pc", PC, 32'h0);

        repeat (3) step();
        chk("seq_id_pc4", ID_PC4, 32'd12);
        chk("seq_id_ins", ID_Ins, 32'h2008_0003);

        Br_Taken = 1; Br_Target = 32'h41; Jmp = 1; Jmp_Target = 32'h80;
        step(); idle();
        chk("br_pc", PC, 32'h40);
        chk("br_squash", 32'(ID_Valid), 32'h0);

        Stall = 1; Br_Taken = 1; Br_Target = 32'h10;
        repeat (2) begin
            step();
            chk("stall_pc", PC, 32'h40);
        end
        Stall = 0; step(); idle();
        chk("stall_release_pc", PC, 32'h10);

        step();
        chk("halt_id_ins", ID_Ins, HALT_WORD);
        chk("halt_id_valid", 32'(ID_Valid), 32'h1);
        chk("halt_flag", 32'(Halted), 32'h1);
        chk("halt_pc", PC, 32'h10);
        step();
        chk("halt_hold_pc", PC, 32'h10);
        chk("halt_squash", 32'(ID_Valid), 32'h0);

        // Overflow: one word more than the memory holds.
        Load_Start = 1; step(); idle();
        chk("load_exit_halt", 32'(Halted), 32'h0);
        for (int i = 0; i <= IMEM_SIZE; i++) begin
            Load_Valid = 1; Load_Data = rand_word();
            step();
        end
        chk("load_ovf_set", 32'(Load_Ovf), 32'h1);
        Load_Valid = 1; Load_Data = 32'h1234_5678; step();
        RST = 1; step(); idle();
        chk("midload_rst_pc", PC, 32'h0);
        chk("midload_rst_ovf", 32'(Load_Ovf), 32'h0);

        // Random phase.
        for (int c = 0; c < 4000; c++) begin
            idle();
            RST        = ($urandom_range(0, 199) == 0);
            Load_Start = ($urandom_range(0, 39) == 0);
            Load_Valid = ($urandom_range(0, 1) == 0);
            Load_Data  = rand_word();
            Load_Done  = ($urandom_range(0, 24) == 0);
            Stall      = ($urandom_range(0, 4) == 0);
            Br_Taken   = ($urandom_range(0, 9) == 0);
            Jmp        = ($urandom_range(0, 9) == 0);
            Br_Target  = ($urandom_range(0, 19) == 0) ? $urandom() : 32'($urandom_range(0, IMEM_SIZE * 4 - 1));
            Jmp_Target = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(IMEM_SIZE * 4 - 8, IMEM_SIZE * 4 + 64))
                                                      : 32'($urandom_range(0, IMEM_SIZE * 4 - 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
